// File: rtl/jtag_uart_sys_cpu_debug_ocimem.sv
// On-chip debug memory shared by the JTAG monitor and the CPU debug slave.
// JTAG commands are buffered in a single pending slot and take priority over the CPU.
module jtag_uart_sys_cpu_debug_ocimem #(
    parameter int unsigned RAM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [37:0] jdo,
    input  logic        take_action_ocimem_a,
    input  logic        take_no_action_ocimem_a,
    input  logic        take_action_ocimem_b,
    input  logic [8:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    input  logic        debugaccess,
    output logic [31:0] readdata,
    output logic        waitrequest,
    output logic [31:0] MonDReg,
    output logic        monitor_ready,
    output logic        monitor_error
);

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned JW = 38;

    typedef enum logic [2:0] {IDLE, J_RD, J_WR, J_DONE, C_RD, C_DONE} state_t;
    typedef enum logic [1:0] {CMD_A, CMD_NA, CMD_B} cmd_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_pend_vld;
    cmd_t            r_pend_kind;
    logic [JW-1:0]   r_pend_jdo;
    logic [AW-1:0]   r_mon_a;
    logic [DW-1:0]   r_mon_d;
    logic [DW-1:0]   r_readdata;
    logic            r_ready;
    logic            r_error;
    logic [DW-1:0]   r_mem [RAM_DEPTH];

    logic            w_pulse;
    cmd_t            w_pulse_kind;
    logic            w_idle;
    logic            w_cmd_vld;
    cmd_t            w_cmd_kind;
    logic [JW-1:0]   w_cmd_jdo;
    logic            w_dispatch;
    logic            w_accept;
    logic            w_capture;
    logic            w_drop;
    logic            w_jwr_en;
    logic            w_cwr_en;
    logic            w_ram_we;
    logic [AW-1:0]   w_ram_addr;
    logic [DW-1:0]   w_ram_wdata;
    logic [3:0]      w_ram_be;
    logic [DW-1:0]   w_regwin;
    logic            w_unused;

    // Command source: the pending slot first, else a live pulse seen while idle.
    assign w_pulse      = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign w_pulse_kind = take_action_ocimem_a    ? CMD_A  :
                          take_no_action_ocimem_a ? CMD_NA : CMD_B;
    assign w_idle       = (r_state == IDLE);
    assign w_cmd_vld    = r_pend_vld | w_pulse;
    assign w_cmd_kind   = r_pend_vld ? r_pend_kind : w_pulse_kind;
    assign w_cmd_jdo    = r_pend_vld ? r_pend_jdo  : jdo;
    assign w_dispatch   = w_idle & w_cmd_vld;

    // The slot frees on dispatch, so a pulse in that same cycle can refill it.
    assign w_accept     = w_pulse & (~r_pend_vld | w_idle);
    assign w_capture    = w_pulse & (r_pend_vld ? w_idle : ~w_idle);
    assign w_drop       = w_pulse & r_pend_vld & ~w_idle;

    assign w_regwin     = {r_error, r_ready, 22'b0, r_mon_a};
    assign w_unused     = ^{w_cmd_jdo[37], w_cmd_jdo[2:0]};

    always_comb begin
        w_state_nxt = r_state;
        w_jwr_en    = 1'b0;
        w_cwr_en    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cmd_vld) begin
                    case (w_cmd_kind)
                        CMD_A:   w_state_nxt = w_cmd_jdo[35] ? J_RD : J_DONE;
                        CMD_NA:  w_state_nxt = J_RD;
                        default: begin
                            w_state_nxt = J_WR;
                            w_jwr_en    = 1'b1;
                        end
                    endcase
                end else if (read) begin
                    w_state_nxt = C_RD;
                end else if (write) begin
                    w_state_nxt = C_DONE;
                    w_cwr_en    = ~address[8] & debugaccess;
                end
            end
            J_RD:    w_state_nxt = J_DONE;
            J_WR:    w_state_nxt = J_DONE;
            J_DONE:  w_state_nxt = IDLE;
            C_RD:    w_state_nxt = C_DONE;
            C_DONE:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Single write port shared by JTAG (full word) and CPU (byte lanes).
    assign w_ram_we    = (w_jwr_en | w_cwr_en) & ~reset;
    assign w_ram_addr  = w_jwr_en ? r_mon_a : address[7:0];
    assign w_ram_wdata = w_jwr_en ? w_cmd_jdo[34:3] : writedata;
    assign w_ram_be    = w_jwr_en ? 4'hF : byteenable;

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_ram_be[i]) begin
                    r_mem[w_ram_addr][8*i +: 8] <= w_ram_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_pend_vld  <= 1'b0;
            r_pend_kind <= CMD_A;
            r_pend_jdo  <= '0;
            r_mon_a     <= '0;
            r_mon_d     <= '0;
            r_readdata  <= '0;
            r_ready     <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_capture) begin
                r_pend_vld  <= 1'b1;
                r_pend_kind <= w_pulse_kind;
                r_pend_jdo  <= jdo;
            end else if (w_dispatch) begin
                r_pend_vld  <= 1'b0;
            end

            if (w_dispatch && w_cmd_kind == CMD_A) begin
                r_mon_a <= w_cmd_jdo[25:18];
            end else if (w_dispatch && w_cmd_kind == CMD_NA) begin
                r_mon_a <= r_mon_a + 8'd1;
            end else if (r_state == J_WR) begin
                r_mon_a <= r_mon_a + 8'd1;
            end

            if (r_state == J_RD) begin
                r_mon_d <= r_mem[r_mon_a];
            end

            if (r_state == C_RD) begin
                r_readdata <= address[8] ? w_regwin : r_mem[address[7:0]];
            end

            if (w_accept || w_dispatch) begin
                r_ready <= 1'b0;
            end else if (r_state == J_DONE) begin
                r_ready <= 1'b1;
            end

            // A dropped pulse wins over a clear in the same cycle.
            if (w_drop) begin
                r_error <= 1'b1;
            end else if (w_dispatch && w_cmd_kind == CMD_A && w_cmd_jdo[36]) begin
                r_error <= 1'b0;
            end
        end
    end

    assign waitrequest   = (read | write) & (r_state != C_DONE);
    assign readdata      = r_readdata;
    assign MonDReg       = r_mon_d;
    assign monitor_ready = r_ready;
    assign monitor_error = r_error;

endmodule

// File: tb/tb_jtag_uart_sys_cpu_debug_ocimem.sv
// Scoreboard bench: the driver queues expected responses, a negedge monitor
// compares them when the DUT completes a CPU access or raises monitor_ready.
module tb_jtag_uart_sys_cpu_debug_ocimem;

    logic        clk;
    logic        reset;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_no_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic [8:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        debugaccess;
    logic [31:0] readdata;
    logic        waitrequest;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;

    jtag_uart_sys_cpu_debug_ocimem #(.RAM_DEPTH(256)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .address                 (address),
        .read                    (read),
        .write                   (write),
        .writedata               (writedata),
        .byteenable              (byteenable),
        .debugaccess             (debugaccess),
        .readdata                (readdata),
        .waitrequest             (waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic chk_d; logic [31:0] d; logic err; int lat; } jexp_t;
    typedef struct { logic is_rd; logic [31:0] d; int lat; } cexp_t;
    typedef struct { logic rdy; logic err; logic [31:0] mond; logic [31:0] rdata; } sexp_t;

    jexp_t q_jtag[$];
    cexp_t q_cpu[$];
    sexp_t q_st[$];

    logic chk_stb;
    logic done_req;

    int n_total;
    int n_bad;
    int cpu_cyc;
    int pulse_cyc;
    logic prev_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Monitor: all comparisons happen here.
    initial begin
        n_total = 0; n_bad = 0; cpu_cyc = 0; pulse_cyc = 0; prev_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (take_action_ocimem_a || take_no_action_ocimem_a || take_action_ocimem_b)
                pulse_cyc = 0;
            else
                pulse_cyc++;

            if (monitor_ready && !prev_ready) begin
                if (q_jtag.size() == 0) begin
                    chk("jtag_unexpected_ready", 32'd1, 32'd0);
                end else begin
                    jexp_t e;
                    e = q_jtag.pop_front();
                    chk("jtag_error", 32'(monitor_error), 32'(e.err));
                    if (e.chk_d) chk("jtag_mondreg", MonDReg, e.d);
                    if (e.lat != 0) chk("jtag_latency", 32'(pulse_cyc), 32'(e.lat));
                end
            end
            prev_ready = monitor_ready;

            if (reset) begin
                cpu_cyc = 0;
            end else if (read || write) begin
                if (waitrequest) begin
                    cpu_cyc++;
                end else begin
                    if (q_cpu.size() == 0) begin
                        chk("cpu_unexpected_done", 32'd1, 32'd0);
                    end else begin
                        cexp_t c;
                        c = q_cpu.pop_front();
                        chk("cpu_latency", 32'(cpu_cyc), 32'(c.lat));
                        if (c.is_rd) chk("cpu_readdata", readdata, c.d);
                    end
                    cpu_cyc = 0;
                end
            end else begin
                cpu_cyc = 0;
            end

            if (chk_stb) begin
                if (q_st.size() == 0) begin
                    chk("status_unexpected", 32'd1, 32'd0);
                end else begin
                    sexp_t s;
                    s = q_st.pop_front();
                    chk("st_ready", 32'(monitor_ready), 32'(s.rdy));
                    chk("st_error", 32'(monitor_error), 32'(s.err));
                    chk("st_mondreg", MonDReg, s.mond);
                    chk("st_readdata", readdata, s.rdata);
                end
            end

            if (done_req) begin
                chk("jtag_left", 32'(q_jtag.size()), 32'd0);
                chk("cpu_left", 32'(q_cpu.size()), 32'd0);
                chk("st_left", 32'(q_st.size()), 32'd0);
                $display("test done: total=%0d bad=%0d", n_total, n_bad);
                $finish;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [37:0] ja(input logic rd, input logic clr, input logic [7:0] a);
        logic [37:0] j;
        j = '0; j[35] = rd; j[36] = clr; j[25:18] = a;
        return j;
    endfunction

    function automatic logic [37:0] jb(input logic [31:0] d);
        logic [37:0] j;
        j = '0; j[34:3] = d;
        return j;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic jexp(input logic cd, input logic [31:0] d, input logic err, input int lat);
        jexp_t e;
        e.chk_d = cd; e.d = d; e.err = err; e.lat = lat;
        q_jtag.push_back(e);
    endtask

    // kind: 0 action_a, 1 no_action_a, 2 action_b; waits for the op to finish.
    task automatic jtag(input int kind, input logic [37:0] j);
        jdo = j;
        take_action_ocimem_a    = (kind == 0);
        take_no_action_ocimem_a = (kind == 1);
        take_action_ocimem_b    = (kind == 2);
        tick();
        take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
        repeat (5) tick();
    endtask

    task automatic wait_cpu_done();
        for (int i = 0; i < 30 && waitrequest; i++) tick();
        if (waitrequest) begin
            $display("FAIL cpu_timeout: waitrequest still %0d after 30 cycles, expected 0", waitrequest);
            $fatal(1);
        end
        tick();
        read = 1'b0; write = 1'b0;
    endtask

    task automatic cpu(input logic rd, input logic [8:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input logic dbg, input logic [31:0] exp, input int lat);
        cexp_t c;
        c.is_rd = rd; c.d = exp; c.lat = lat;
        q_cpu.push_back(c);
        address = a; writedata = wd; byteenable = be; debugaccess = dbg;
        read = rd; write = ~rd;
        tick();
        wait_cpu_done();
    endtask

    task automatic status(input logic rdy, input logic err, input logic [31:0] mond, input logic [31:0] rdata);
        sexp_t s;
        s.rdy = rdy; s.err = err; s.mond = mond; s.rdata = rdata;
        q_st.push_back(s);
        chk_stb = 1'b1;
        tick();
        chk_stb = 1'b0;
    endtask

    initial begin
        reset = 1'b1; jdo = '0; address = '0; read = 1'b0; write = 1'b0;
        writedata = '0; byteenable = '0; debugaccess = 1'b0;
        take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
        chk_stb = 1'b0; done_req = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        status(1'b0, 1'b0, 32'h0, 32'h0);
        cpu(1'b1, 9'h100, 32'h0, 4'hF, 1'b1, 32'h0000_0000, 2);

        // Load address 0x10, write DEADBEEF, address post-increments
        jexp(1'b0, 32'h0, 1'b0, 0); jtag(0, ja(1'b0, 1'b0, 8'h10));
        jexp(1'b0, 32'h0, 1'b0, 0); jtag(2, jb(32'hDEAD_BEEF));
        cpu(1'b1, 9'h100, 32'h0, 4'hF, 1'b1, 32'h4000_0011, 2);
        cpu(1'b1, 9'h010, 32'h0, 4'hF, 1'b1, 32'hDEAD_BEEF, 2);

        // JTAG read-back
        jexp(1'b1, 32'hDEAD_BEEF, 1'b0, 3); jtag(0, ja(1'b1, 1'b0, 8'h10));

        // Address wrap 0xFF -> 0x00 with read
        jexp(1'b0, 32'h0, 1'b0, 0); jtag(0, ja(1'b0, 1'b0, 8'h00));
        jexp(1'b0, 32'h0, 1'b0, 0); jtag(2, jb(32'hA5A5_0001));
        jexp(1'b0, 32'h0, 1'b0, 0); jtag(0, ja(1'b0, 1'b0, 8'hFF));
        jexp(1'b1, 32'hA5A5_0001, 1'b0, 0); jtag(1, 38'h0);
        cpu(1'b1, 9'h100, 32'h0, 4'hF, 1'b1, 32'h4000_0000, 2);

        // CPU byte-lane writes, debugaccess gating, register-window write ignored
        cpu(1'b0, 9'h005, 32'h0000_0000, 4'hF, 1'b1, 32'h0, 1);
        cpu(1'b0, 9'h005, 32'h1234_5678, 4'b0011, 1'b1, 32'h0, 1);
        cpu(1'b1, 9'h005, 32'h0, 4'hF, 1'b1, 32'h0000_5678, 2);
        cpu(1'b0, 9'h005, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0, 1);
        cpu(1'b1, 9'h005, 32'h0, 4'hF, 1'b1, 32'h0000_5678, 2);
        cpu(1'b0, 9'h100, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0, 1);
        cpu(1'b1, 9'h100, 32'h0, 4'hF, 1'b1, 32'h4000_0000, 2);

        // CPU read and JTAG read in the same idle cycle: JTAG first
        begin
            cexp_t c;
            c.is_rd = 1'b1; c.d = 32'h0000_5678; c.lat = 5;
            q_cpu.push_back(c);
            jexp(1'b1, 32'hDEAD_BEEF, 1'b0, 3);
            address = 9'h005; read = 1'b1;
            jdo = ja(1'b1, 1'b0, 8'h10); take_action_ocimem_a = 1'b1;
            tick();
            take_action_ocimem_a = 1'b0;
            wait_cpu_done();
            repeat (3) tick();
        end

        // Three pulses around a CPU access: run, pend, drop
        begin
            cexp_t c;
            c.is_rd = 1'b1; c.d = 32'hDEAD_BEEF; c.lat = 2;
            q_cpu.push_back(c);
            address = 9'h010; read = 1'b1;
            tick(); tick();
            jexp(1'b1, 32'h0000_5678, 1'b1, 0);
            jdo = ja(1'b1, 1'b0, 8'h05); take_action_ocimem_a = 1'b1;
            tick();
            read = 1'b0;
            jexp(1'b0, 32'h0, 1'b1, 0);
            jdo = ja(1'b0, 1'b0, 8'h20);
            tick();
            take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b1;
            jdo = jb(32'h0000_1111);
            tick();
            take_action_ocimem_b = 1'b0;
            repeat (6) tick();
        end
        status(1'b1, 1'b1, 32'h0000_5678, 32'hDEAD_BEEF);
        cpu(1'b1, 9'h100, 32'h0, 4'hF, 1'b1, 32'hC000_0020, 2);
        jexp(1'b0, 32'h0, 1'b0, 0); jtag(0, ja(1'b0, 1'b1, 8'h30));
        cpu(1'b1, 9'h100, 32'h0, 4'hF, 1'b1, 32'h4000_0030, 2);

        // Reset coincident with a JTAG write: no write, RAM preserved
        jexp(1'b0, 32'h0, 1'b0, 0); jtag(0, ja(1'b0, 1'b0, 8'h10));
        jdo = jb(32'hBAD0_BAD0); take_action_ocimem_b = 1'b1; reset = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
        tick();
        reset = 1'b0;
        status(1'b0, 1'b0, 32'h0, 32'h0);
        cpu(1'b1, 9'h100, 32'h0, 4'hF, 1'b1, 32'h0000_0000, 2);
        cpu(1'b1, 9'h010, 32'h0, 4'hF, 1'b1, 32'hDEAD_BEEF, 2);

        repeat (4) tick();
        done_req = 1'b1;
        tick();
        tick();
    end

endmodule
